// File: rtl/dmem_lsu_master_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_if
// Description : Bundle of the request, response and data-memory signals of
//               the load/store initiator.
//   req_*  : valid/ready load/store request from the execute stage
//   rsp_*  : valid/ready load data / store completion back to the core
//   mem_*  : word-wide data memory port (mem_rw: 1 = read, 0 = write)
//   Modport master : the load/store unit side
//   Modport slave  : the core + memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_lsu_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rw;
    logic [31:0]   mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_rw,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_rw,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_master
// Description : Load/store initiator between the execute stage and a
//               word-wide data memory. One byte/half/word access per
//               transaction; sub-word stores use read-modify-write.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_lsu_if.master (request, response and memory signals)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_master #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dmem_lsu_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_depth = AW'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_word;

    logic          w_accept;
    logic          w_err;
    logic [4:0]    w_lane_sh;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load_data;
    logic [31:0]   w_lane_mask;
    logic [31:0]   w_store_word;

    assign w_accept = bus.req_valid && (r_state == IDLE);

    // Error decode works on the live request so the next state can be chosen
    // in the acceptance cycle; the range check uses the full word index.
    assign w_err = (bus.req_size == 2'b11)
                || ((bus.req_size == 2'b01) && bus.req_addr[0])
                || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                || ({2'b00, bus.req_addr[AW-1:2]} >= c_depth);

    // Lane position inside the word: bytes on any offset, halves on bit 1.
    assign w_lane_sh   = (r_size == 2'b00) ? {r_addr[1:0], 3'b000}
                                           : {r_addr[1], 4'b0000};
    assign w_shifted   = r_word >> w_lane_sh;
    assign w_lane_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)
                         << w_lane_sh;

    always_comb begin
        w_load_data = r_word;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = r_word;
        endcase
    end

    // Word stores write the request data directly; sub-word stores splice
    // the right-aligned store data into the word captured during RD.
    assign w_store_word = (r_size == 2'b10)
                        ? r_wdata
                        : ((r_word & ~w_lane_mask)
                           | ((r_wdata << w_lane_sh) & w_lane_mask));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request and read-word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_word     <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_err      <= w_err;
            end
            if (r_state == RD) begin
                r_word <= bus.mem_rdata;
            end
        end
    end

    // Next state and outputs. Memory strobes are decoded from the state so
    // an asynchronous reset returns mem_rw to read immediately.
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.mem_rw    = 1'b1;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = 32'({2'b00, r_addr[AW-1:2]});

        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err) begin
                        w_state_nxt = RSP;
                    end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                        w_state_nxt = WR;
                    end else begin
                        w_state_nxt = RD;
                    end
                end
            end
            RD: begin
                w_state_nxt = r_we ? WR : RSP;
            end
            WR: begin
                bus.mem_rw    = 1'b0;
                bus.mem_wdata = w_store_word;
                w_state_nxt   = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = (r_err || r_we) ? 32'h0 : w_load_data;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu_master
// Description : Directed self-checking bench for dmem_lsu_master with a
//               256-word behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_master;

    logic clk;
    logic rst_n;

    dmem_lsu_if #(.AW(32)) bus ();

    dmem_lsu_master #(.DEPTH(256), .AW(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge while mem_rw = 0
    logic [31:0] mem [0:255];
    int          wr_cnt;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    assign bus.mem_rdata = (bus.mem_addr < 32'd256) ? mem[bus.mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            if (bus.mem_addr < 32'd256) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.mem_addr;
            last_wr_data <= bus.mem_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat = cycle index after the acceptance edge in
    // which rsp_valid is first seen, nwr = memory writes during it.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nwr);
        int w0;
        int guard;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b0;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        w0 = wr_cnt;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.req_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 10);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        nwr = wr_cnt - w0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          nw;
    int          w0;

    initial begin
        wr_cnt           = 0;
        last_wr_addr     = 32'h0;
        last_wr_data     = 32'h0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata,          32'h0);
        chk("rst_mem_addr",  bus.mem_addr,           32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,          32'h0);
        chk("rst_mem_rw",    {31'h0, bus.mem_rw},    32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store then load at 0x10
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt, nw);
        chk("wst_lat",   lt,           2);
        chk("wst_err",   {31'h0, er},  32'h0);
        chk("wst_rdata", rd,           32'h0);
        chk("wst_nwr",   nw,           1);
        chk("wst_addr",  last_wr_addr, 32'h4);
        chk("wst_data",  last_wr_data, 32'hDEADBEEF);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, nw);
        chk("wld_lat",   lt,          2);
        chk("wld_rdata", rd,          32'hDEADBEEF);
        chk("wld_err",   {31'h0, er}, 32'h0);
        chk("wld_nwr",   nw,          0);

        // Byte and half read-modify-write stores on word 1
        xact(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, rd, er, lt, nw);
        xact(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, rd, er, lt, nw);
        chk("bst_lat",  lt,           3);
        chk("bst_nwr",  nw,           1);
        chk("bst_addr", last_wr_addr, 32'h1);
        chk("bst_data", last_wr_data, 32'h11AA3344);
        xact(1'b1, 2'b01, 1'b0, 32'h04, 32'h1234BEEF, rd, er, lt, nw);
        chk("hst_lat",  lt,           3);
        chk("hst_data", last_wr_data, 32'h11AABEEF);
        xact(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, rd, er, lt, nw);
        chk("hld_u_hi", rd, 32'h000011AA);
        xact(1'b0, 2'b00, 1'b0, 32'h07, 32'h0, rd, er, lt, nw);
        chk("bld_s_b3", rd, 32'h00000011);

        // Sign / zero extension on word 2 = 0x0000F080
        xact(1'b1, 2'b10, 1'b0, 32'h08, 32'h0000F080, rd, er, lt, nw);
        xact(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, rd, er, lt, nw);
        chk("bld_s",     rd, 32'hFFFFFF80);
        chk("bld_s_lat", lt, 2);
        xact(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, rd, er, lt, nw);
        chk("bld_u", rd, 32'h00000080);
        xact(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, rd, er, lt, nw);
        chk("bld_s_b1", rd, 32'hFFFFFFF0);
        xact(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, rd, er, lt, nw);
        chk("hld_s", rd, 32'hFFFFF080);
        xact(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, rd, er, lt, nw);
        chk("hld_s_hi", rd, 32'h00000000);

        // Last in-range word
        xact(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h12345678, rd, er, lt, nw);
        xact(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, er, lt, nw);
        chk("top_rdata", rd,          32'h12345678);
        chk("top_err",   {31'h0, er}, 32'h0);

        // Errors: misaligned half, misaligned word store, size 11, out of range
        xact(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, rd, er, lt, nw);
        chk("e_half_err", {31'h0, er}, 32'h1);
        chk("e_half_rd",  rd,          32'h0);
        chk("e_half_lat", lt,          1);
        chk("e_half_nwr", nw,          0);
        xact(1'b1, 2'b10, 1'b0, 32'h0A, 32'hFFFFFFFF, rd, er, lt, nw);
        chk("e_wst_err", {31'h0, er}, 32'h1);
        chk("e_wst_lat", lt,          1);
        chk("e_wst_nwr", nw,          0);
        chk("e_wst_mem", mem[2],      32'h0000F080);
        xact(1'b1, 2'b11, 1'b0, 32'h00, 32'h55555555, rd, er, lt, nw);
        chk("e_sz_err", {31'h0, er}, 32'h1);
        chk("e_sz_lat", lt,          1);
        chk("e_sz_nwr", nw,          0);
        xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lt, nw);
        chk("e_rng_err", {31'h0, er}, 32'h1);
        chk("e_rng_rd",  rd,          32'h0);
        chk("e_rng_lat", lt,          1);

        // Backpressure on a word load of 0x10; a second request waits
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid0", {31'h0, bus.rsp_valid}, 32'h1);
        bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h0BADF00D; bus.req_valid = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            chk("bp_rdata", bus.rsp_rdata,          32'hDEADBEEF);
            chk("bp_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        chk("bp_nowr", wr_cnt - w0, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_drop",  {31'h0, bus.rsp_valid}, 32'h0);
        chk("bp_rdy",   {31'h0, bus.req_ready}, 32'h1);
        chk("bp_nowr2", wr_cnt - w0,            0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp2_rw",    {31'h0, bus.mem_rw}, 32'h0);
        chk("bp2_addr",  bus.mem_addr,        32'h8);
        chk("bp2_wdata", bus.mem_wdata,       32'h0BADF00D);
        @(negedge clk);
        chk("bp2_valid", {31'h0, bus.rsp_valid}, 32'h1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp2_nwr", wr_cnt - w0, 1);
        chk("bp2_mem", mem[8],      32'h0BADF00D);

        // Reset during the RD cycle of a byte store
        xact(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D, rd, er, lt, nw);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_addr = 32'h0C;
        bus.req_wdata = 32'h00000055; bus.req_valid = 1'b1;
        w0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rm_rd_addr", bus.mem_addr, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("rm_rw",    {31'h0, bus.mem_rw},    32'h1);
        chk("rm_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rm_addr",  bus.mem_addr,           32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rm_nowr",   wr_cnt - w0,            0);
        chk("rm_mem",    mem[3],                 32'hCAFEF00D);
        chk("rm_ready2", {31'h0, bus.req_ready}, 32'h1);
        chk("rm_valid",  {31'h0, bus.rsp_valid}, 32'h0);
        xact(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, rd, er, lt, nw);
        chk("rm_reload", rd, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu_master.md
Name: dmem_lsu_master

Overview:
- Load/store initiator sitting between the core's execute stage and the word-wide data memory.
- Accepts one byte/half/word load or store per transaction over a valid/ready request channel.
- Drives the memory's word address, write data and read/write strobe (1 = read, 0 = write).
- Returns sign- or zero-extended load data, or a store completion, on a valid/ready response channel.
- Sub-word stores use read-modify-write because the memory writes only whole words.

Parameters:
- DEPTH, 256: memory depth in 32-bit words; word index >= DEPTH is out of range.
- AW, 32: request byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size, or out-of-range access.
- mem_addr  out  32  word index (byte address >> 2).
- mem_wdata  out  32  word to write.
- mem_rw  out  1  1 = read, 0 = write (memory writes on the rising clk edge while 0).
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0.
  - rsp_rdata = 0, mem_addr = 0, mem_wdata = 0, mem_rw = 1.
  - Reset mid-transaction abandons it with no memory write; mem_rw is forced to 1 immediately.
- Outside the WR state, mem_rw = 1 and mem_wdata = 0. mem_rw is 0 in exactly one cycle per store.
- States: IDLE, RD, WR, RSP. req_ready = (state == IDLE).
- IDLE:
  - On req_valid, register we, size, unsigned, addr, wdata.
  - Decode the error: size 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[AW-1:2] >= DEPTH.
  - Error -> RSP with rsp_err = 1 and no memory access.
  - Load, or store of byte/half -> RD.
  - Word store -> WR.
- RD (1 cycle):
  - mem_addr = word index, mem_rw = 1.
  - Capture mem_rdata at the clock edge.
  - Load -> RSP. Sub-word store -> WR.
- WR (1 cycle):
  - mem_rw = 0, mem_addr = word index.
  - mem_wdata is either req_wdata (word store) or the captured word with the byte/half lane replaced.
  - Byte lane = addr[1:0]*8; half lane = addr[1]*16.
  - Next state RSP.
- Load extraction:
  - Byte = captured word >> (addr[1:0]*8), low 8 bits.
  - Half = captured word >> (addr[1]*16), low 16 bits.
  - Extend to 32 bits per req_unsigned; word loads pass through unchanged.
- RSP:
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable until rsp_ready.
  - When rsp_valid and rsp_ready are both high -> IDLE, rsp_valid = 0 next cycle.
  - A new request cannot be accepted in the same cycle as the response handshake; req_ready rises the following cycle.
- Latency, acceptance edge to first rsp_valid cycle:
  - Load: 2 cycles. Word store: 2. Sub-word store: 3. Error: 1.
- One outstanding transaction at a time; no back-to-back overlap.
- The word index is truncated to 32 bits on mem_addr; the range check uses the full index.

Test Plan:
- Word store then load:
  - Store addr 0x10, data 0xDEADBEEF -> one cycle with mem_rw = 0, mem_addr = 4, mem_wdata = 0xDEADBEEF.
  - Then load word at 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after acceptance.
- Byte store read-modify-write:
  - Memory word 1 = 0x11223344; store byte 0xAA to addr 0x06.
  - Response -> RD then WR with mem_wdata = 0x11AA3344, rsp_valid 3 cycles after acceptance.
- Sign/zero extension:
  - Word 2 = 0x0000F080.
  - Load byte at 0x08, signed -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Load half at 0x08, signed -> 0xFFFFF080.
- Errors:
  - Half load at 0x03, word store at 0x0A, size 11, or addr 0x400 with DEPTH = 256.
  - Each -> rsp_err = 1, rsp_rdata = 0, mem_rw never 0, rsp_valid 1 cycle after acceptance.
- Backpressure:
  - Hold rsp_ready = 0 for 5 cycles on a load.
  - Response -> rsp_valid and rsp_rdata stable throughout, req_ready = 0, a second req_valid is ignored; accepted only the cycle after the handshake.
- Reset mid-store:
  - Deassert rst_n during the RD cycle of a byte store.
  - Response -> mem_rw = 1 immediately, target word unchanged, req_ready = 1 after release.
